dsp_add_lanes: RTL and testbench

DSP_ADD_LANES -- requirements
Module: dsp_add_lanes

---
 rtl/dsp_add_lanes.sv | 95 +++++++++
 tb/tb_dsp_add_lanes.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dsp_add_lanes.sv
// dsp_add_lanes
//   Per-lane modular adder mapped onto a 48-bit DSP-style SIMD ALU, with a
//   registered output (one clock of latency, a new operand pair every cycle).
//
//   Lane packing: lane i sits at bits [i*width +: width] of a, b and y.
//   ALU mapping (48-bit datapath split into equal SIMD slots):
//     lanes=1 -> one 48-bit slot
//     lanes=2 -> two 24-bit slots
//     lanes=3 -> four 12-bit slots, the top slot unused (operands tied to 0)
//   Each lane is zero-extended into its slot. The slot adders cannot carry
//   into each other, so lanes wrap independently. Slot bits above width,
//   including each lane's carry-out, are dropped on the way to y.
//
// Parameters
//   width : bits per lane
//   lanes : number of lanes (1, 2 or 3)
// Ports
//   clock : rising-edge clock
//   reset : synchronous, active-low reset; clears y
//   a, b  : packed operands, lanes*width bits
//   y     : packed registered sums, lanes*width bits
module dsp_add_lanes #(
  parameter int width = 8,
  parameter int lanes = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [lanes*width-1:0] a,
  input  logic [lanes*width-1:0] b,
  output logic [lanes*width-1:0] y
);

  localparam int ALU_W  = 48;
  localparam int SLOT_W = (lanes == 1) ? 48 : (lanes == 2) ? 24 : 12;
  localparam int NSLOT  = ALU_W / SLOT_W;

  // Reject any (lanes, width) pair that does not fit its SIMD slot.
  localparam bit LEGAL = ((lanes == 1) && (width >= 1) && (width <= 48)) ||
                         ((lanes == 2) && (width >= 1) && (width <= 24)) ||
                         ((lanes == 3) && (width >= 1) && (width <= 12));

  generate
    if (!LEGAL) begin : g_bad_params
      $error("dsp_add_lanes: illegal lanes/width combination");
    end
  endgenerate

  logic [ALU_W-1:0]       w_alu_a;
  logic [ALU_W-1:0]       w_alu_b;
  logic [ALU_W-1:0]       w_alu_sum;
  logic [lanes*width-1:0] w_y;
  logic [lanes*width-1:0] r_y;

  // Zero-extend each lane into its slot. Slots with no lane (the fourth
  // slot when lanes=3) keep the all-zero default.
  always_comb begin
    w_alu_a = '0;
    w_alu_b = '0;
    for (int i = 0; i < lanes; i++) begin
      w_alu_a[i*SLOT_W +: width] = a[i*width +: width];
      w_alu_b[i*SLOT_W +: width] = b[i*width +: width];
    end
  end

  // SIMD slot adders: each sum is truncated to the slot width, so a slot's
  // carry-out is dropped rather than rippling into the next slot.
  generate
    for (genvar s = 0; s < NSLOT; s++) begin : g_slot
      assign w_alu_sum[s*SLOT_W +: SLOT_W] =
        w_alu_a[s*SLOT_W +: SLOT_W] + w_alu_b[s*SLOT_W +: SLOT_W];
    end
  endgenerate

  // Keep only the low width bits of each occupied slot.
  always_comb begin
    w_y = '0;
    for (int i = 0; i < lanes; i++) begin
      w_y[i*width +: width] = w_alu_sum[i*SLOT_W +: width];
    end
  end

  // Bits above each lane and the unused slot never reach y. This reduction
  // only marks them as intentionally dropped.
  logic w_unused_slot_bits;
  assign w_unused_slot_bits = ^w_alu_sum;

  // Output register. Reset takes precedence over the add on the same edge.
  always_ff @(posedge clock) begin
    if (!reset) r_y <= '0;
    else        r_y <= w_y;
  end

  assign y = r_y;

endmodule

// File: tb/tb_dsp_add_lanes.sv
module tb_dsp_add_lanes;

  // DUT corners: index -> (lanes, width)
  localparam int NI = 6;
  localparam int LN [NI] = '{1, 1, 2, 3, 1, 1};
  localparam int WD [NI] = '{8, 32, 24, 12, 48, 1};

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [47:0] ta [NI];
  logic [47:0] tb [NI];
  logic [47:0] yv [NI];

  logic [7:0]  y0;
  logic [31:0] y1;
  logic [47:0] y2;
  logic [35:0] y3;
  logic [47:0] y4;
  logic [0:0]  y5;

  dsp_add_lanes #(.width(8),  .lanes(1)) u_l1_w8  (.clock(clock), .reset(reset), .a(ta[0][7:0]),  .b(tb[0][7:0]),  .y(y0));
  dsp_add_lanes #(.width(32), .lanes(1)) u_l1_w32 (.clock(clock), .reset(reset), .a(ta[1][31:0]), .b(tb[1][31:0]), .y(y1));
  dsp_add_lanes #(.width(24), .lanes(2)) u_l2_w24 (.clock(clock), .reset(reset), .a(ta[2][47:0]), .b(tb[2][47:0]), .y(y2));
  dsp_add_lanes #(.width(12), .lanes(3)) u_l3_w12 (.clock(clock), .reset(reset), .a(ta[3][35:0]), .b(tb[3][35:0]), .y(y3));
  dsp_add_lanes #(.width(48), .lanes(1)) u_l1_w48 (.clock(clock), .reset(reset), .a(ta[4][47:0]), .b(tb[4][47:0]), .y(y4));
  dsp_add_lanes #(.width(1),  .lanes(1)) u_l1_w1  (.clock(clock), .reset(reset), .a(ta[5][0:0]),  .b(tb[5][0:0]),  .y(y5));

  assign yv[0] = 48'(y0);
  assign yv[1] = 48'(y1);
  assign yv[2] = y2;
  assign yv[3] = 48'(y3);
  assign yv[4] = y4;
  assign yv[5] = 48'(y5);

  int n_pass  = 0;
  int n_total = 0;

  // Reference: each lane is an independent unsigned add modulo 2^width.
  function automatic logic [47:0] model(input int k, input logic [47:0] a, input logic [47:0] b);
    logic [47:0] r;
    longint unsigned m, la, lb, s;
    r = '0;
    m = (64'd1 << WD[k]) - 64'd1;
    for (int i = 0; i < LN[k]; i++) begin
      la = (64'(a) >> (i * WD[k])) & m;
      lb = (64'(b) >> (i * WD[k])) & m;
      s  = (la + lb) % (m + 64'd1);
      r  = r | 48'(s << (i * WD[k]));
    end
    return r;
  endfunction

  function automatic logic [47:0] rnd48();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[47:0];
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_random();
    for (int k = 0; k < NI; k++) begin
      ta[k] = rnd48();
      tb[k] = rnd48() | 48'h1;
    end
  endtask

  task automatic test_reset();
    // Held reset with nonzero operands: y stays zero.
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive_random();
      step();
      for (int k = 0; k < NI; k++) begin
        n_total++;
        if (yv[k] !== 48'h0) $display("FAIL reset_hold inst%0d edge%0d: got %h want 0", k, c, yv[k]);
        else n_pass++;
      end
    end
    // Release: first edge loads the sum (inst0 uses the wrap vector).
    drive_random();
    ta[0] = 48'hFF; tb[0] = 48'h10;
    reset = 1'b1;
    step();
    n_total++;
    if (yv[0] !== 48'h0F) $display("FAIL reset_release_wrap: got %h want 0f", yv[0]);
    else n_pass++;
    for (int k = 1; k < NI; k++) begin
      n_total++;
      if (yv[k] !== model(k, ta[k], tb[k])) $display("FAIL reset_release inst%0d: got %h want %h", k, yv[k], model(k, ta[k], tb[k]));
      else n_pass++;
    end
    // Stream a few cycles, then reassert reset mid-stream.
    for (int c = 0; c < 3; c++) begin
      drive_random();
      step();
    end
    drive_random();
    reset = 1'b0;
    step();
    for (int k = 0; k < NI; k++) begin
      n_total++;
      if (yv[k] !== 48'h0) $display("FAIL reset_midstream inst%0d: got %h want 0", k, yv[k]);
      else n_pass++;
    end
    reset = 1'b1;
  endtask

  task automatic test_vectors();
    drive_random();
    ta[1] = 48'h0000_0000_0001;   tb[1] = 48'h0000_FFFF_0001;
    ta[2] = 48'h000017_FFFFFF;    tb[2] = 48'h000007_000010;
    ta[3] = 48'h000_019_FE9_001;  tb[3] = 48'h000_007_FF9_FF0;
    step();
    n_total++;
    if (yv[1] !== 48'hFFFF0002) $display("FAIL vec_l1_w32: got %h want ffff0002", yv[1]);
    else n_pass++;
    n_total++;
    if (yv[2] !== 48'h00001E_00000F) $display("FAIL vec_l2_w24: got %h want 00001e00000f", yv[2]);
    else n_pass++;
    n_total++;
    if (yv[3] !== 48'h020FE2FF1) $display("FAIL vec_l3_w12: got %h want 020fe2ff1", yv[3]);
    else n_pass++;
  endtask

  task automatic test_all_ones_wrap();
    // Every lane all-ones + 1 wraps to zero with no cross-lane carry.
    logic [47:0] one_per_lane;
    for (int k = 0; k < NI; k++) begin
      one_per_lane = '0;
      for (int i = 0; i < LN[k]; i++) one_per_lane = one_per_lane | (48'h1 << (i * WD[k]));
      ta[k] = '1;
      tb[k] = one_per_lane;
    end
    step();
    for (int k = 0; k < NI; k++) begin
      n_total++;
      if (yv[k] !== 48'h0) $display("FAIL wrap_all_ones inst%0d: got %h want 0", k, yv[k]);
      else n_pass++;
    end
  endtask

  task automatic test_latency();
    // New operands must not show on y before the next edge.
    logic [47:0] prev [NI];
    drive_random();
    step();
    for (int k = 0; k < NI; k++) prev[k] = model(k, ta[k], tb[k]);
    drive_random();
    #2;
    for (int k = 0; k < NI; k++) begin
      n_total++;
      if (yv[k] !== prev[k]) $display("FAIL latency_hold inst%0d: got %h want %h", k, yv[k], prev[k]);
      else n_pass++;
    end
    step();
    for (int k = 0; k < NI; k++) begin
      n_total++;
      if (yv[k] !== model(k, ta[k], tb[k])) $display("FAIL latency_load inst%0d: got %h want %h", k, yv[k], model(k, ta[k], tb[k]));
      else n_pass++;
    end
  endtask

  task automatic test_streaming();
    logic [47:0] exp_q [NI];
    for (int c = 0; c < 1000; c++) begin
      for (int k = 0; k < NI; k++) begin
        ta[k] = rnd48();
        tb[k] = rnd48();
        exp_q[k] = model(k, ta[k], tb[k]);
      end
      step();
      for (int k = 0; k < NI; k++) begin
        n_total++;
        if (yv[k] !== exp_q[k]) $display("FAIL stream inst%0d cyc%0d: got %h want %h", k, c, yv[k], exp_q[k]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      ta[k] = '0;
      tb[k] = '0;
    end
    test_reset();
    test_vectors();
    test_all_ones_wrap();
    test_latency();
    test_streaming();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
